// File: rtl/fsm_sweep_pkg.sv
// Shared types and widths for the FSM table sweeper.
// These widths are fixed for the 4-state / 2-bit-input / 1-output Moore blocks.
package fsm_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    REACH = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  localparam int NUM_STATES  = 4;
  localparam int NUM_INPUTS  = 4;
  localparam int STATE_W     = 2;
  localparam int IN_W        = 2;
  localparam int IDX_W       = 4;
  localparam int TBL_W       = 32;
  // With 4 states, three closure steps from {0} always reach the fixpoint.
  localparam int REACH_ITERS = 3;

endpackage

// File: rtl/fsm_reach_step.sv
// One reachability closure step: adds every successor of every currently reachable state.
module fsm_reach_step
  import fsm_sweep_pkg::*;
(
  input  logic [NUM_STATES-1:0] reach,
  input  logic [TBL_W-1:0]      tbl_next,
  output logic [NUM_STATES-1:0] reach_next
);

  always_comb begin
    reach_next = reach;
    for (int s = 0; s < NUM_STATES; s++) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (reach[s]) begin
          reach_next[tbl_next[STATE_W*(NUM_INPUTS*s + i) +: STATE_W]] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fsm_table_sweeper.sv
// Sweeps all (state, in_) pairs through an attached comb Moore FSM, captures its table,
// checks the Moore property and computes the set of states reachable from state 0.
module fsm_table_sweeper
  import fsm_sweep_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [STATE_W-1:0]    dut_state,
  output logic [IN_W-1:0]       dut_in_,
  input  logic [STATE_W-1:0]    dut_state_next,
  input  logic                  dut_out,
  output logic [TBL_W-1:0]      tbl_next,
  output logic [NUM_STATES-1:0] tbl_out,
  output logic                  moore_err,
  output logic [NUM_STATES-1:0] reach
);

  sweep_state_t          state;
  logic [IDX_W-1:0]      idx;
  logic [1:0]            reach_cnt;
  logic [NUM_STATES-1:0] reach_next;

  fsm_reach_step u_reach_step (
    .reach      (reach),
    .tbl_next   (tbl_next),
    .reach_next (reach_next)
  );

  // {dut_state, dut_in_} always equals idx during SWEEP, so the capture slot is idx itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      reach_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dut_state <= '0;
      dut_in_   <= '0;
      tbl_next  <= '0;
      tbl_out   <= '0;
      moore_err <= 1'b0;
      reach     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SWEEP;
            busy      <= 1'b1;
            idx       <= '0;
            dut_state <= '0;
            dut_in_   <= '0;
            tbl_next  <= '0;
            tbl_out   <= '0;
            moore_err <= 1'b0;
            reach     <= '0;
          end
        end

        SWEEP: begin
          tbl_next[{idx, 1'b0} +: STATE_W] <= dut_state_next;
          if (idx[1:0] == 2'd0) begin
            tbl_out[idx[3:2]] <= dut_out;
          end else if (dut_out != tbl_out[idx[3:2]]) begin
            moore_err <= 1'b1;
          end

          if (&idx) begin
            state                <= REACH;
            idx                  <= '0;
            {dut_state, dut_in_} <= '0;
            reach                <= NUM_STATES'(1);
            reach_cnt            <= '0;
          end else begin
            idx                  <= idx + 1'b1;
            {dut_state, dut_in_} <= idx + 1'b1;
          end
        end

        REACH: begin
          reach     <= reach_next;
          reach_cnt <= reach_cnt + 1'b1;
          if (reach_cnt == 2'(REACH_ITERS - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_table_sweeper.sv
// Table-driven bench for fsm_table_sweeper: a behavioural comb FSM selectable by mode,
// plus hand sequences for ignored starts, mid-sweep reset and reset/start collisions.
module tb_fsm_table_sweeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  dut_state;
  logic [1:0]  dut_in_;
  logic [1:0]  dut_state_next;
  logic        dut_out;
  logic [31:0] tbl_next;
  logic [3:0]  tbl_out;
  logic        moore_err;
  logic [3:0]  reach;

  int checks = 0;
  int passes = 0;
  int mode   = 0;

  fsm_table_sweeper dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .dut_state      (dut_state),
    .dut_in_        (dut_in_),
    .dut_state_next (dut_state_next),
    .dut_out        (dut_out),
    .tbl_next       (tbl_next),
    .tbl_out        (tbl_out),
    .moore_err      (moore_err),
    .reach          (reach)
  );

  always #5 clk = ~clk;

  // Behavioural comb FSMs under test
  always_comb begin
    dut_state_next = dut_state;
    dut_out        = 1'b0;
    case (mode)
      0: begin dut_state_next = dut_state; dut_out = dut_state[0]; end
      1: begin
        dut_state_next = (dut_in_ == 2'd0) ? dut_state : dut_state + 2'd1;
        dut_out        = (dut_state == 2'd3);
      end
      2: begin dut_state_next = dut_state; dut_out = dut_in_[0]; end
      3: begin dut_state_next = dut_in_; dut_out = 1'b0; end
      4: begin
        dut_state_next = (dut_state == 2'd0) ? 2'd1 : dut_state;
        dut_out        = (dut_state == 2'd2);
      end
      5: begin
        dut_state_next = dut_state;
        dut_out        = ({dut_state, dut_in_} == 4'd15) ? ~dut_state[1] : dut_state[1];
      end
      default: ;
    endcase
  end

  typedef struct {
    int          vmode;
    logic [31:0] exp_tbl;
    logic [3:0]  exp_out;
    logic        exp_err;
    logic [3:0]  exp_reach;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Pulses start, then samples each negedge; cycle 1 is the cycle right after the start edge.
  task automatic apply_stimulus(input int pulse_a, input int pulse_b,
                                output int done_cyc, output int done_cnt,
                                output bit seq_ok, output bit clr_ok);
    done_cyc = 0; done_cnt = 0; seq_ok = 1'b1; clr_ok = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 1 && (moore_err !== 1'b0 || tbl_next !== 32'h0 || tbl_out !== 4'h0 || reach !== 4'h0))
        clr_ok = 1'b0;
      if (cyc <= 16 && {dut_state, dut_in_} !== 4'(cyc - 1)) seq_ok = 1'b0;
      if (cyc >= 21 && {dut_state, dut_in_} !== 4'h0) seq_ok = 1'b0;
      if ((cyc <= 19) != (busy === 1'b1)) seq_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      start = (cyc == pulse_a || cyc == pulse_b);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_output(input vec_t v, input int done_cyc, input int done_cnt,
                              input bit seq_ok, input bit clr_ok);
    check($sformatf("latency m%0d", v.vmode), done_cyc, 20);
    check($sformatf("done_count m%0d", v.vmode), done_cnt, 1);
    check($sformatf("drive_busy_seq m%0d", v.vmode), {31'b0, seq_ok}, 1);
    check($sformatf("clear_at_start m%0d", v.vmode), {31'b0, clr_ok}, 1);
    check($sformatf("tbl_next m%0d", v.vmode), tbl_next, v.exp_tbl);
    check($sformatf("tbl_out m%0d", v.vmode), {28'b0, tbl_out}, {28'b0, v.exp_out});
    check($sformatf("moore_err m%0d", v.vmode), {31'b0, moore_err}, {31'b0, v.exp_err});
    check($sformatf("reach m%0d", v.vmode), {28'b0, reach}, {28'b0, v.exp_reach});
  endtask

  initial begin
    int dc, dn;
    bit sq, cl;
    int late_done;

    vecs[0] = '{0, 32'hFFAA_5500, 4'b1010, 1'b0, 4'b0001};
    vecs[1] = '{1, 32'h03FE_A954, 4'b1000, 1'b0, 4'b1111};
    vecs[2] = '{2, 32'hFFAA_5500, 4'b0000, 1'b1, 4'b0001};
    vecs[3] = '{0, 32'hFFAA_5500, 4'b1010, 1'b0, 4'b0001};
    vecs[4] = '{3, 32'hE4E4_E4E4, 4'b0000, 1'b0, 4'b1111};
    vecs[5] = '{4, 32'hFFAA_5555, 4'b0100, 1'b0, 4'b0011};
    vecs[6] = '{5, 32'hFFAA_5500, 4'b1100, 1'b1, 4'b0001};

    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, busy}, 0);
    check("reset done", {31'b0, done}, 0);
    check("reset drive", {28'b0, dut_state, dut_in_}, 0);
    check("reset tables", {tbl_next[27:0], tbl_out}, 0);
    check("reset err_reach", {27'b0, moore_err, reach}, 0);

    // Reset and start together: reset must win.
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("reset_vs_start busy", {31'b0, busy}, 0);

    foreach (vecs[k]) begin
      mode = vecs[k].vmode;
      apply_stimulus(0, 0, dc, dn, sq, cl);
      check_output(vecs[k], dc, dn, sq, cl);
    end

    // Starts during a sweep are ignored.
    mode = 4;
    apply_stimulus(5, 12, dc, dn, sq, cl);
    check_output(vecs[5], dc, dn, sq, cl);

    // Reset in the middle of a sweep discards everything.
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset busy", {31'b0, busy}, 1);
    #2 reset = 1'b1;
    #1;
    check("midreset busy", {31'b0, busy}, 0);
    check("midreset tbl_next", tbl_next, 0);
    check("midreset drive", {28'b0, dut_state, dut_in_}, 0);
    check("midreset out_err_reach", {23'b0, tbl_out, moore_err, reach}, 0);
    @(negedge clk);
    reset = 1'b0;
    late_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) late_done++;
    end
    check("no_done_after_reset", late_done, 0);

    mode = 1;
    apply_stimulus(0, 0, dc, dn, sq, cl);
    check_output(vecs[1], dc, dn, sq, cl);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
